md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL expose parameter TIMEOUT, default 6'd48, the number of BUSY/DRAIN cycles without md_ready before the operation is forced to finish.
REQ-002 SHALL have one clock; reset is asynchronous and active-low (ports: clock, reset_n).
REQ-003 clock  in  1  rising-edge clock shared with the mult/div units.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 insn_valid  in  1  the execute-stage instruction is valid.
REQ-006 is_mul, is_div  in  1 each  opcode decode; both high is illegal and is treated as is_div.
REQ-007 flush  in  1  pipeline kill; the in-flight result is discarded.
REQ-008 op_a, op_b  in  32 each  source operands.
REQ-009 rd  in  5  destination register.
REQ-010 md_result  in  32  unit result, valid on md_ready.
REQ-011 md_exception  in  1  unit exception, valid on md_ready.
REQ-012 md_ready  in  1  one-cycle completion pulse from the unit.
REQ-013 ctrl_MULT, ctrl_DIV  out  1 each  one-cycle start pulses to the units.
REQ-014 data_operandA, data_operandB  out  32 each  registered operands to the units.
REQ-015 stall  out  1  freezes upstream pipeline stages.
REQ-016 wb_valid  out  1  one-cycle writeback strobe.
REQ-017 wb_rd  out  5  writeback destination.
REQ-018 wb_data  out  32  writeback data.
REQ-019 wb_exception  out  1  exception flag qualified by wb_valid.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, BUSY, DRAIN and DONE.
REQ-021 req = insn_valid & (is_mul | is_div) & ~flush.
REQ-022 IDLE SHALL, on req, latch op_a/op_b into data_operandA/B, latch rd and the op type, and go to ISSUE; otherwise it stays in IDLE.
REQ-023 ISSUE SHALL assert exactly one of ctrl_MULT/ctrl_DIV for one cycle, clear the timeout counter, and go to BUSY, or to DRAIN if flush is high.
REQ-024 data_operandA/B SHALL hold their latched values from ISSUE until the next IDLE->ISSUE transition.
REQ-025 BUSY SHALL increment a 6-bit timeout counter each cycle.
REQ-026 In BUSY, on md_ready & ~flush, SHALL register wb_data=md_result, wb_exception=md_exception, wb_rd=latched rd, and go to DONE.
REQ-027 In BUSY, on flush without md_ready, SHALL go to DRAIN without resetting the counter.
REQ-028 In BUSY, on flush & md_ready in the same cycle, flush SHALL win: discard the result and go to IDLE.
REQ-029 In BUSY, when the counter reaches TIMEOUT-1 without md_ready, SHALL go to DONE with wb_data=0 and wb_exception=1.
REQ-030 DRAIN SHALL discard the result and go to IDLE on md_ready or on timeout; a new req is not accepted until IDLE.
REQ-031 DONE SHALL assert wb_valid for exactly one cycle and return to IDLE; a req arriving in DONE is accepted on the following IDLE cycle.
REQ-032 stall SHALL be combinational: (IDLE & req) | ISSUE | BUSY | (DRAIN & insn_valid & (is_mul|is_div)). stall is 0 in DONE.
REQ-033 md_ready SHALL be ignored in IDLE, ISSUE and DONE (stray pulse: no wb_valid).
REQ-034 Latency from accepted req to wb_valid SHALL be N+2 cycles, where md_ready arrives N cycles after the ctrl pulse (N>=1).
REQ-035 wb_rd/wb_data/wb_exception SHALL hold their last value outside DONE.

Reset
REQ-036 On reset_n=0, all outputs SHALL go to 0 immediately and the state to IDLE.
REQ-037 The counter, latched operands, rd and op type SHALL clear to 0.
REQ-038 Reset mid-operation SHALL abandon the operation; a late md_ready after reset is ignored per REQ-033.

Verification
REQ-039 DIV op_a=100, op_b=7, rd=5; model unit returns 14 after N=34 -> one ctrl_DIV pulse, stall high 36 cycles, wb_valid at cycle 36, wb_rd=5, wb_data=14, wb_exception=0.
REQ-040 MUL op_a=-3, op_b=4; md_ready N=17 with result 0xFFFFFFF4 -> one ctrl_MULT pulse only, wb_data=0xFFFFFFF4.
REQ-041 DIV with md_exception=1 and md_result=0 (divide by zero) -> wb_exception=1, wb_data=0, wb_valid for 1 cycle.
REQ-042 Flush 5 cycles after issue, md_ready 29 cycles later -> no wb_valid; stall drops after the flush; a new DIV req during DRAIN stalls until IDLE, then issues.
REQ-043 Unit never responds -> wb_valid 48 cycles after entering BUSY with wb_exception=1 and wb_data=0.
REQ-044 reset_n pulsed low during BUSY, then stray md_ready -> all outputs 0 and no wb_valid; the next req issues normally.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
// Issue controller sitting between the execute stage and the iterative
// multiply/divide units. It accepts one mult/div instruction at a time,
// registers its operands, fires a one-cycle start pulse to the right unit,
// stalls the upstream pipeline while the unit works, and produces a one-cycle
// writeback strobe when the unit answers. A watchdog counter forces
// completion (with an exception) if the unit never answers. A pipeline flush
// discards the in-flight result; the controller then drains the unit before
// accepting new work.
//
// Ports
//   clock, reset_n              clock and asynchronous active-low reset
//   insn_valid, is_mul, is_div  execute-stage instruction valid and decode
//   flush                       pipeline kill
//   op_a, op_b, rd              source operands and destination register
//   md_result, md_exception     unit result/exception, valid on md_ready
//   md_ready                    one-cycle completion pulse from the unit
//   ctrl_MULT, ctrl_DIV         one-cycle start pulses to the units
//   data_operandA/B             registered operands to the units
//   stall                       freezes upstream stages (combinational)
//   wb_valid                    one-cycle writeback strobe
//   wb_rd, wb_data, wb_exception writeback payload, held between strobes
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
  parameter logic [5:0] TIMEOUT = 6'd48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        insn_valid,
  input  logic        is_mul,
  input  logic        is_div,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_rd;
  logic        r_op_div;
  logic        r_ctrl_mult;
  logic        r_ctrl_div;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_exc;

  logic        w_md_op;
  logic        w_req;
  logic        w_timeout;

  assign w_md_op   = is_mul | is_div;
  assign w_req     = insn_valid & w_md_op & ~flush;
  // Counter reads 0 in the first BUSY cycle, so TIMEOUT-1 marks the
  // TIMEOUT-th cycle spent waiting for the unit.
  assign w_timeout = (r_cnt == (TIMEOUT - 6'd1));

  // Next-state decode for the issue FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          // Flush beats a same-cycle answer or timeout: nothing left to drain.
          if (md_ready | w_timeout) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (md_ready | w_timeout) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DRAIN: begin
        if (md_ready | w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and watchdog counter (counter keeps running into DRAIN)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ISSUE) begin
        r_cnt <= 6'd0;
      end else if ((r_state == S_BUSY) || (r_state == S_DRAIN)) begin
        r_cnt <= r_cnt + 6'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Operand/destination latch on acceptance and the start pulse for ISSUE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_rd        <= 5'd0;
      r_op_div    <= 1'b0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_op_a      <= op_a;
      r_op_b      <= op_b;
      r_rd        <= rd;
      // Both decode bits high is treated as a divide.
      r_op_div    <= is_div;
      r_ctrl_mult <= ~is_div;
      r_ctrl_div  <= is_div;
    end else begin
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
    end
  end

  // Writeback capture: unit answer or forced timeout completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_wb_exc   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if ((r_state == S_BUSY) && !flush) begin
        if (md_ready) begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_data  <= md_result;
          r_wb_exc   <= md_exception;
        end else if (w_timeout) begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_data  <= 32'd0;
          r_wb_exc   <= 1'b1;
        end
      end
    end
  end

  // Gated by reset_n so every output reads 0 while reset is held.
  assign stall = reset_n & (((r_state == S_IDLE) & w_req) |
                            (r_state == S_ISSUE) |
                            (r_state == S_BUSY) |
                            ((r_state == S_DRAIN) & insn_valid & w_md_op));

  assign ctrl_MULT     = r_ctrl_mult;
  assign ctrl_DIV      = r_ctrl_div;
  assign data_operandA = r_op_a;
  assign data_operandB = r_op_b;
  assign wb_valid      = r_wb_valid;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign wb_exception  = r_wb_exc;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
// Self-checking bench for md_issue_ctrl. A transaction-level reference model
// (tracks whether an operation is in flight, its age in cycles since the
// start pulse, and whether it was killed) predicts every output each cycle.
// Directed sequences cover the documented scenarios; a randomized phase
// mixes requests, flushes, answers and silent units.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        insn_valid, is_mul, is_div, flush;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  localparam int TMO = 48;

  md_issue_ctrl #(.TIMEOUT(6'd48)) dut (
    .clock(clock), .reset_n(reset_n), .insn_valid(insn_valid),
    .is_mul(is_mul), .is_div(is_div), .flush(flush),
    .op_a(op_a), .op_b(op_b), .rd(rd),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: one operation in flight, aged from its start pulse
  bit          m_active, m_killed, m_wb, m_div;
  int          m_age;
  logic [31:0] m_a, m_b, m_wb_data;
  logic [4:0]  m_rd, m_wb_rd;
  logic        m_wb_exc;

  // per-sequence observations
  int          n_stall, n_cm, n_cd, n_wb, wb_at;
  logic [31:0] seen_data;
  logic [4:0]  seen_rd;
  logic        seen_exc;
  bit          stall_hist [0:79];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_killed = 1'b0; m_wb = 1'b0; m_div = 1'b0; m_age = 0;
    m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0;
    m_wb_data = 32'd0; m_wb_rd = 5'd0; m_wb_exc = 1'b0;
  endtask

  task automatic model_update();
    bit req, resolve;
    req = insn_valid & (is_mul | is_div) & ~flush;
    if (m_wb) begin
      m_wb = 1'b0;
    end else if (!m_active) begin
      if (req) begin
        m_active = 1'b1; m_killed = 1'b0; m_age = 0;
        m_a = op_a; m_b = op_b; m_rd = rd; m_div = is_div;
      end
    end else if (m_age == 0) begin
      m_killed = flush;
      m_age = 1;
    end else begin
      resolve = md_ready || (m_age == TMO);
      if (m_killed || flush) begin
        if (resolve) m_active = 1'b0;
        else begin m_killed = 1'b1; m_age++; end
      end else if (md_ready) begin
        m_active = 1'b0; m_wb = 1'b1;
        m_wb_data = md_result; m_wb_exc = md_exception; m_wb_rd = m_rd;
      end else if (m_age == TMO) begin
        m_active = 1'b0; m_wb = 1'b1;
        m_wb_data = 32'd0; m_wb_exc = 1'b1; m_wb_rd = m_rd;
      end else begin
        m_age++;
      end
    end
  endtask

  // one clock cycle: compare at negedge, advance model, return after posedge
  task automatic tick();
    bit e_stall, req;
    @(negedge clock);
    req = insn_valid & (is_mul | is_div) & ~flush;
    e_stall = (!m_active && !m_wb && req) || (m_active && !m_killed) ||
              (m_active && m_killed && insn_valid && (is_mul || is_div));
    check_eq("ctrl_mult", 32'(ctrl_MULT), 32'(m_active && m_age == 0 && !m_div));
    check_eq("ctrl_div",  32'(ctrl_DIV),  32'(m_active && m_age == 0 && m_div));
    check_eq("opA", data_operandA, m_a);
    check_eq("opB", data_operandB, m_b);
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("wb_valid", 32'(wb_valid), 32'(m_wb));
    check_eq("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
    check_eq("wb_data", wb_data, m_wb_data);
    check_eq("wb_exc", 32'(wb_exception), 32'(m_wb_exc));
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    insn_valid = 1'b0; is_mul = 1'b0; is_div = 1'b0; flush = 1'b0;
    op_a = 32'd0; op_b = 32'd0; rd = 5'd0;
    md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0;
  endtask

  // directed sequence: op at cycle 0, optional flush, optional second DIV req
  task automatic run_seq(input bit div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input int ready_at, input logic [31:0] res,
                         input bit exc, input int flush_at, input int req2_from,
                         input int req2_to, input int ready2_at, input int len);
    n_stall = 0; n_cm = 0; n_cd = 0; n_wb = 0; wb_at = -1;
    seen_data = 32'd0; seen_rd = 5'd0; seen_exc = 1'b0;
    for (int k = 0; k < len; k++) begin
      insn_valid   = (k == 0) || (k >= req2_from && k <= req2_to);
      is_div       = (k == 0) ? div : 1'b1;
      is_mul       = (k == 0) ? ~div : 1'b0;
      op_a         = (k == 0) ? a : 32'd9;
      op_b         = (k == 0) ? b : 32'd3;
      rd           = (k == 0) ? r : 5'd7;
      flush        = (k == flush_at);
      md_ready     = (k == ready_at) || (k == ready2_at);
      md_result    = (k == ready_at) ? res : 32'h0000_5A5A;
      md_exception = (k == ready_at) ? exc : 1'b0;
      @(negedge clock);
      if (k < 80) stall_hist[k] = stall;
      if (stall) n_stall++;
      if (ctrl_MULT) n_cm++;
      if (ctrl_DIV) n_cd++;
      if (wb_valid) begin
        n_wb++;
        if (wb_at < 0) wb_at = k;
        seen_data = wb_data; seen_rd = wb_rd; seen_exc = wb_exception;
      end
      @(posedge clock);
      #1;
      // rewind into tick's window: tick re-samples at the following negedge,
      // so do the model check on a separate path below
    end
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    int mode;
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check_eq("rst_opA", data_operandA, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    $display("directed sequences");
    // DIV 100/7 -> 14 after N=34
    seq_checked(1'b1, 32'd100, 32'd7, 5'd5, 35, 32'd14, 1'b0, -1, -1, -1, -1, 40);
    check_eq("A_ctrl_div", n_cd, 32'd1);
    check_eq("A_ctrl_mult", n_cm, 32'd0);
    check_eq("A_stall_cycles", n_stall, 32'd36);
    check_eq("A_wb_at", wb_at, 32'd36);
    check_eq("A_wb_cnt", n_wb, 32'd1);
    check_eq("A_wb_rd", 32'(seen_rd), 32'd5);
    check_eq("A_wb_data", seen_data, 32'd14);
    check_eq("A_wb_exc", 32'(seen_exc), 32'd0);

    // MUL -3*4, N=17
    seq_checked(1'b0, 32'hFFFF_FFFD, 32'd4, 5'd9, 18, 32'hFFFF_FFF4, 1'b0, -1, -1, -1, -1, 22);
    check_eq("B_ctrl_mult", n_cm, 32'd1);
    check_eq("B_ctrl_div", n_cd, 32'd0);
    check_eq("B_wb_at", wb_at, 32'd19);
    check_eq("B_wb_data", seen_data, 32'hFFFF_FFF4);

    // divide by zero reported by the unit
    seq_checked(1'b1, 32'd5, 32'd0, 5'd2, 11, 32'd0, 1'b1, -1, -1, -1, -1, 15);
    check_eq("C_wb_cnt", n_wb, 32'd1);
    check_eq("C_wb_exc", 32'(seen_exc), 32'd1);
    check_eq("C_wb_data", seen_data, 32'd0);

    // flush 5 cycles after issue, late answer, new DIV req during DRAIN
    seq_checked(1'b1, 32'd8, 32'd2, 5'd4, 35, 32'd77, 1'b0, 6, 20, 36, 45, 50);
    cnt = 0;
    for (int k = 0; k < 20; k++) if (stall_hist[k]) cnt++;
    check_eq("D_stall_pre", cnt, 32'd7);
    cnt = 0;
    for (int k = 20; k <= 36; k++) if (stall_hist[k]) cnt++;
    check_eq("D_stall_drain", cnt, 32'd17);
    check_eq("D_ctrl_div", n_cd, 32'd2);
    check_eq("D_wb_cnt", n_wb, 32'd1);
    check_eq("D_wb_at", wb_at, 32'd46);
    check_eq("D_wb_rd", 32'(seen_rd), 32'd7);

    // silent unit -> forced completion 48 cycles after entering BUSY
    seq_checked(1'b1, 32'd1, 32'd1, 5'd11, -1, 32'd0, 1'b0, -1, -1, -1, -1, 55);
    check_eq("E_wb_at", wb_at, 32'd50);
    check_eq("E_wb_exc", 32'(seen_exc), 32'd1);
    check_eq("E_wb_data", seen_data, 32'd0);
    check_eq("E_wb_rd", 32'(seen_rd), 32'd11);

    // reset during BUSY, then a stray md_ready
    seq_checked(1'b0, 32'd3, 32'd3, 5'd6, -1, 32'd0, 1'b0, -1, -1, -1, -1, 10);
    reset_n = 1'b0;
    #2;
    check_eq("F_rst_stall", 32'(stall), 32'd0);
    check_eq("F_rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check_eq("F_rst_opA", data_operandA, 32'd0);
    check_eq("F_rst_opB", data_operandB, 32'd0);
    check_eq("F_rst_wb", 32'({wb_valid, wb_exception, wb_rd}), 32'd0);
    check_eq("F_rst_wb_data", wb_data, 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    md_ready = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
    tick();
    clear_inputs();
    tick();
    seq_checked(1'b0, 32'd6, 32'd7, 5'd3, 4, 32'd42, 1'b0, -1, -1, -1, -1, 8);
    check_eq("F_next_wb_at", wb_at, 32'd5);
    check_eq("F_next_wb_data", seen_data, 32'd42);
    check_eq("F_next_ctrl_mult", n_cm, 32'd1);

    $display("randomized phase");
    for (int blk = 0; blk < 10; blk++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 200; c++) begin
        insn_valid   = $urandom_range(0, 1) == 1;
        is_mul       = $urandom_range(0, 1) == 1;
        is_div       = $urandom_range(0, 1) == 1;
        flush        = $urandom_range(0, 24) == 0;
        op_a         = $urandom;
        op_b         = $urandom;
        rd           = 5'($urandom_range(0, 31));
        md_result    = $urandom;
        md_exception = $urandom_range(0, 7) == 0;
        md_ready     = (mode == 0) ? ($urandom_range(0, 5) == 0) :
                       (mode == 1) ? ($urandom_range(0, 39) == 0) : 1'b0;
        tick();
      end
    end
    clear_inputs();
    for (int c = 0; c < 60; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // directed sequence with the reference model checked on every cycle
  task automatic seq_checked(input bit div, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] r, input int ready_at, input logic [31:0] res,
                             input bit exc, input int flush_at, input int req2_from,
                             input int req2_to, input int ready2_at, input int len);
    n_stall = 0; n_cm = 0; n_cd = 0; n_wb = 0; wb_at = -1;
    seen_data = 32'd0; seen_rd = 5'd0; seen_exc = 1'b0;
    for (int k = 0; k < len; k++) begin
      insn_valid   = (k == 0) || (k >= req2_from && k <= req2_to);
      is_div       = (k == 0) ? div : 1'b1;
      is_mul       = (k == 0) ? ~div : 1'b0;
      op_a         = (k == 0) ? a : 32'd9;
      op_b         = (k == 0) ? b : 32'd3;
      rd           = (k == 0) ? r : 5'd7;
      flush        = (k == flush_at);
      md_ready     = (k == ready_at) || (k == ready2_at);
      md_result    = (k == ready_at) ? res : 32'h0000_5A5A;
      md_exception = (k == ready_at) ? exc : 1'b0;
      @(negedge clock);
      if (k < 80) stall_hist[k] = stall;
      if (stall) n_stall++;
      if (ctrl_MULT) n_cm++;
      if (ctrl_DIV) n_cd++;
      if (wb_valid) begin
        n_wb++;
        if (wb_at < 0) wb_at = k;
        seen_data = wb_data; seen_rd = wb_rd; seen_exc = wb_exception;
      end
      check_cycle();
      @(posedge clock);
      #1;
    end
    clear_inputs();
  endtask

  // model comparison for the current cycle (caller is already at the negedge)
  task automatic check_cycle();
    bit e_stall, req;
    req = insn_valid & (is_mul | is_div) & ~flush;
    e_stall = (!m_active && !m_wb && req) || (m_active && !m_killed) ||
              (m_active && m_killed && insn_valid && (is_mul || is_div));
    check_eq("ctrl_mult", 32'(ctrl_MULT), 32'(m_active && m_age == 0 && !m_div));
    check_eq("ctrl_div",  32'(ctrl_DIV),  32'(m_active && m_age == 0 && m_div));
    check_eq("opA", data_operandA, m_a);
    check_eq("opB", data_operandB, m_b);
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("wb_valid", 32'(wb_valid), 32'(m_wb));
    check_eq("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
    check_eq("wb_data", wb_data, m_wb_data);
    check_eq("wb_exc", 32'(wb_exception), 32'(m_wb_exc));
    model_update();
  endtask

endmodule
